// File: rtl/buf_pkg.sv
// Shared definitions for the LIFO/FIFO buffer.
//   MODE_LIFO / MODE_FIFO : values of the mode input and the registered mode
//   ptr_inc               : pointer increment that wraps at an arbitrary depth
package buf_pkg;

    localparam logic MODE_LIFO = 1'b0;
    localparam logic MODE_FIFO = 1'b1;

    // Depth need not be a power of two, so the wrap is an explicit compare.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/buf_regfile.sv
// DEPTH x WIDTH_DATA register file for the LIFO/FIFO buffer.
//   clk   : rising-edge clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read)
//   rdata : read data
// Storage is intentionally not reset.
module buf_regfile #(
    parameter int unsigned WIDTH_DATA = 16,
    parameter int unsigned DEPTH      = 10,
    localparam int unsigned PW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [PW-1:0]         waddr,
    input  logic [WIDTH_DATA-1:0] wdata,
    input  logic [PW-1:0]         raddr,
    output logic [WIDTH_DATA-1:0] rdata
);

    logic [WIDTH_DATA-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_fifo_buffer.sv
// Run-time selectable LIFO (stack) / FIFO (queue) buffer.
//   clk, reset  : clock, synchronous active-low reset
//   mode        : 0=LIFO, 1=FIFO; adopted only while empty and not pushing
//   push, pop   : write data_in / read one entry (both may be set together)
//   data_in     : write data
//   clear_err   : clears sticky error flags (a same-cycle error wins)
//   data_out    : registered read data, holds when no pop is accepted
//   out_valid   : one-cycle pulse when data_out was updated by a pop
//   count       : occupancy; full/empty/almost_full decoded from it
//   overflow    : sticky, push refused while full
//   underflow   : sticky, pop refused while empty
module lifo_fifo_buffer
    import buf_pkg::*;
#(
    parameter int unsigned WIDTH_DATA = 16,
    parameter int unsigned DEPTH      = 10,
    parameter int unsigned AF_MARGIN  = 2,
    localparam int unsigned CW        = $clog2(DEPTH + 1),
    localparam int unsigned PW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mode,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH_DATA-1:0] data_in,
    input  logic                  clear_err,
    output logic [WIDTH_DATA-1:0] data_out,
    output logic                  out_valid,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
);

    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  mode_q, mode_d;
    logic [WIDTH_DATA-1:0] data_out_q, data_out_d;
    logic                  out_valid_q, out_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  is_empty, is_full;
    logic                  push_ok, pop_ok;
    logic [CW-1:0]         top_m1;
    logic [PW-1:0]         waddr, raddr;
    logic [WIDTH_DATA-1:0] rdata;

    always_comb begin
        is_empty    = (count_q == '0);
        is_full     = (count_q == CW'(DEPTH));
        pop_ok      = pop && !is_empty;
        // A full buffer still takes a push when a pop frees a slot in the same cycle.
        push_ok     = push && (!is_full || pop_ok);
        top_m1      = count_q - CW'(1);

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        raddr       = rd_ptr_q;
        waddr       = wr_ptr_q;

        if (mode_q == MODE_LIFO) begin
            raddr = PW'(top_m1);
            // Push with pop replaces the old top instead of stacking above it.
            waddr = pop_ok ? PW'(top_m1) : PW'(count_q);
        end else begin
            if (push_ok) begin
                wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), DEPTH));
            end
            if (pop_ok) begin
                rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), DEPTH));
            end
        end

        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = top_m1;
        end

        mode_d      = (is_empty && !push) ? mode : mode_q;
        data_out_d  = pop_ok ? rdata : data_out_q;
        out_valid_d = pop_ok;

        overflow_d  = overflow_q;
        if (push && !push_ok) begin
            overflow_d = 1'b1;
        end else if (clear_err) begin
            overflow_d = 1'b0;
        end

        underflow_d = underflow_q;
        if (pop && !pop_ok) begin
            underflow_d = 1'b1;
        end else if (clear_err) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mode_q      <= MODE_LIFO;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mode_q      <= mode_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    buf_regfile #(
        .WIDTH_DATA(WIDTH_DATA),
        .DEPTH     (DEPTH)
    ) u_regfile (
        .clk  (clk),
        .we   (push_ok && reset),
        .waddr(waddr),
        .wdata(data_in),
        .raddr(raddr),
        .rdata(rdata)
    );

    assign data_out    = data_out_q;
    assign out_valid   = out_valid_q;
    assign count       = count_q;
    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= CW'(DEPTH - AF_MARGIN));
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_lifo_fifo_buffer.sv
// Self-checking bench for lifo_fifo_buffer (DEPTH=4, WIDTH_DATA=16, AF_MARGIN=1).
// Expectations come from a queue-based reference model of the buffer's rules.
module tb_lifo_fifo_buffer;

    localparam int unsigned W   = 16;
    localparam int unsigned D   = 4;
    localparam int unsigned AFM = 1;
    localparam int unsigned CW  = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          mode = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic          clear_err = 1'b0;
    logic [W-1:0]  data_out;
    logic          out_valid;
    logic [CW-1:0] count;
    logic          full, empty, almost_full, overflow, underflow;

    lifo_fifo_buffer #(
        .WIDTH_DATA(W),
        .DEPTH     (D),
        .AF_MARGIN (AFM)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .push       (push),
        .pop        (pop),
        .data_in    (data_in),
        .clear_err  (clear_err),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .almost_full(almost_full),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [W-1:0] q[$];
    bit           m_mode;
    logic [W-1:0] m_dout;
    bit           m_valid, m_ovf, m_unf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_step();
        bit           pop_ok, push_ok, was_empty;
        logic [W-1:0] rd;
        rd = '0;
        if (!reset) begin
            q.delete();
            m_mode  = 1'b0;
            m_dout  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            return;
        end
        was_empty = (q.size() == 0);
        pop_ok    = pop && !was_empty;
        push_ok   = push && ((q.size() < D) || pop_ok);
        if (pop_ok) begin
            if (m_mode) rd = q.pop_front();
            else        rd = q.pop_back();
            m_dout = rd;
        end
        if (push_ok) q.push_back(data_in);
        m_valid = pop_ok;
        if (push && !push_ok) m_ovf = 1'b1;
        else if (clear_err)   m_ovf = 1'b0;
        if (pop && !pop_ok)   m_unf = 1'b1;
        else if (clear_err)   m_unf = 1'b0;
        if (was_empty && !push) m_mode = mode;
    endtask

    task automatic compare_all();
        check("data_out", 32'(data_out), 32'(m_dout));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("count", 32'(count), q.size());
        check("full", 32'(full), 32'(q.size() == D));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("almost_full", 32'(almost_full), 32'(q.size() >= D - AFM));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic op(input bit p, input bit po, input logic [W-1:0] d);
        push      = p;
        pop       = po;
        data_in   = d;
        clear_err = 1'b0;
        tick();
        push      = 1'b0;
        pop       = 1'b0;
    endtask

    task automatic clr();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
    endtask

    initial begin
        // Reset
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_dout", 32'(data_out), 0);

        // LIFO fill, overflow, drain
        mode = 1'b0;
        for (int i = 1; i <= 4; i++) op(1, 0, 16'(i));
        check("lifo_full", 32'(full), 1);
        op(1, 0, 16'd5);
        check("lifo_ovf", 32'(overflow), 1);
        check("lifo_ovf_count", 32'(count), 4);
        for (int i = 4; i >= 1; i--) begin
            op(0, 1, '0);
            check("lifo_pop", 32'(data_out), i);
            check("lifo_pop_valid", 32'(out_valid), 1);
        end
        check("lifo_drained", 32'(empty), 1);
        clr();

        // FIFO with pointer wrap
        mode = 1'b1;
        op(0, 0, '0);
        op(1, 0, 16'hA); op(1, 0, 16'hB); op(1, 0, 16'hC);
        op(0, 1, '0); check("fifo_pop_a", 32'(data_out), 32'hA);
        op(0, 1, '0); check("fifo_pop_b", 32'(data_out), 32'hB);
        op(1, 0, 16'hD); op(1, 0, 16'hE); op(1, 0, 16'hF);
        check("fifo_wrap_full", 32'(full), 1);
        op(0, 1, '0); check("fifo_pop_c", 32'(data_out), 32'hC);
        op(0, 1, '0); check("fifo_pop_d", 32'(data_out), 32'hD);
        op(0, 1, '0); check("fifo_pop_e", 32'(data_out), 32'hE);
        op(0, 1, '0); check("fifo_pop_f", 32'(data_out), 32'hF);

        // Simultaneous push+pop, LIFO
        mode = 1'b0;
        op(0, 0, '0);
        op(1, 0, 16'd7); op(1, 0, 16'd8);
        op(1, 1, 16'd9);
        check("lifo_pp_dout", 32'(data_out), 8);
        check("lifo_pp_count", 32'(count), 2);
        op(0, 1, '0); check("lifo_pp_next", 32'(data_out), 9);
        op(0, 1, '0); check("lifo_pp_last", 32'(data_out), 7);

        // Simultaneous push+pop, FIFO full
        mode = 1'b1;
        op(0, 0, '0);
        for (int i = 1; i <= 4; i++) op(1, 0, 16'(i));
        op(1, 1, 16'd5);
        check("fifo_pp_dout", 32'(data_out), 1);
        check("fifo_pp_count", 32'(count), 4);
        check("fifo_pp_noovf", 32'(overflow), 0);
        for (int i = 2; i <= 5; i++) begin
            op(0, 1, '0);
            check("fifo_pp_drain", 32'(data_out), i);
        end

        // Empty corner cases
        op(0, 1, '0);
        check("empty_unf", 32'(underflow), 1);
        check("empty_dout_hold", 32'(data_out), 5);
        op(1, 1, 16'h55);
        check("empty_pp_count", 32'(count), 1);
        check("empty_pp_valid", 32'(out_valid), 0);
        clr();
        check("clr_unf", 32'(underflow), 0);
        op(0, 1, '0);

        // Mode change while non-empty is deferred
        mode = 1'b0;
        op(0, 0, '0);
        op(1, 0, 16'd1); op(1, 0, 16'd2);
        mode = 1'b1;
        op(0, 1, '0); check("mode_held_lifo", 32'(data_out), 2);
        op(0, 1, '0); check("mode_held_last", 32'(data_out), 1);
        op(0, 0, '0);
        op(1, 0, 16'd3); op(1, 0, 16'd4);
        op(0, 1, '0); check("mode_now_fifo", 32'(data_out), 3);

        // Reset mid-burst
        op(1, 0, 16'd6);
        reset = 1'b0;
        op(1, 1, 16'd7);
        reset = 1'b1;
        check("midrst_count", 32'(count), 0);
        check("midrst_empty", 32'(empty), 1);
        check("midrst_valid", 32'(out_valid), 0);
        mode = 1'b1;
        op(1, 0, 16'd8); op(1, 0, 16'd9);
        op(0, 1, '0); check("midrst_lifo", 32'(data_out), 9);
        op(0, 1, '0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            reset     = ($urandom_range(0, 99) != 0);
            push      = ($urandom_range(0, 99) < 55);
            pop       = ($urandom_range(0, 99) < 50);
            data_in   = 16'($urandom);
            clear_err = ($urandom_range(0, 15) == 0);
            tick();
        end
        reset     = 1'b1;
        push      = 1'b0;
        pop       = 1'b0;
        clear_err = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
